spi_cmd_master: RTL

- FPGA-side SPI master for our command protocol: issues a 32-bit command frame (8-bit opcode plus 24-bit payload).
- Optionally follows it with a 24-bit response frame read back from the target.
- Sits between on-chip control logic (cmd/rsp handshake) and four SPI pins.
- Used for FPGA-to-FPGA links and as the bench driver for our spi_slave-based designs.

---
 rtl/spi_cmd_master.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: SPI mode-0 master for the command protocol.
// Sends a 32-bit command frame (opcode plus 24-bit payload, low byte of the
// word first, each byte MSB first) and optionally reads back a 24-bit
// response frame after a mandatory SS-high gap.
module spi_cmd_master #(
    parameter int CLK_DIV    = 4,
    parameter int SS_SETUP   = 4,
    parameter int GAP_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [23:0] cmd_data,
    input  logic        cmd_rsp_en,
    output logic        rsp_valid,
    output logic [23:0] rsp_data,
    output logic        busy,
    output logic        SPI_SCK,
    output logic        SPI_SS,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO
);

    localparam int PERIOD  = 2 * CLK_DIV;
    localparam int MAX_A   = (SS_SETUP > PERIOD) ? SS_SETUP : PERIOD;
    localparam int CNT_MAX = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SS_SETUP - 1);
    localparam logic [CNT_W-1:0] HALF        = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [5:0]       CMD_BITS    = 6'd32;
    localparam logic [5:0]       RSP_BITS    = 6'd24;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [5:0]         len_q, len_d;
    logic [31:0]        tx_q, tx_d;
    logic [23:0]        rx_q, rx_d;
    logic               rsp_en_q, rsp_en_d;
    logic               is_rsp_q, is_rsp_d;
    logic               busy_q, busy_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [23:0]        rsp_data_q, rsp_data_d;

    // Register bank; reset parks the block in GAP so SS stays high for a full gap before the first frame
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= GAP;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            len_q       <= CMD_BITS;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_en_q    <= 1'b0;
            is_rsp_q    <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            len_q       <= len_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rsp_en_q    <= rsp_en_d;
            is_rsp_q    <= is_rsp_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next-state logic: one shared cycle counter times setup, bit phases, hold and gap
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        len_d       = len_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rsp_en_d    = rsp_en_q;
        is_rsp_d    = is_rsp_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cmd_valid) begin
                    state_d   = SETUP;
                    tx_d      = {cmd_opcode, cmd_data[7:0], cmd_data[15:8], cmd_data[23:16]};
                    rsp_en_d  = cmd_rsp_en;
                    is_rsp_d  = 1'b0;
                    len_d     = CMD_BITS;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == PERIOD_LAST) begin
                    cnt_d = '0;
                    tx_d  = {tx_q[30:0], 1'b0};
                    rx_d  = {rx_q[22:0], SPI_MISO};
                    if (bit_cnt_q == len_q - 6'd1) begin
                        bit_cnt_d = '0;
                        state_d   = HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                    if (is_rsp_q) begin
                        rsp_data_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16]};
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (rsp_en_q && !is_rsp_q) begin
                        state_d   = SETUP;
                        len_d     = RSP_BITS;
                        is_rsp_d  = 1'b1;
                        tx_d      = '0;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = GAP;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin decode from registered state so reset forces SS high and SCK low without waiting for a clock
    always_comb begin
        cmd_ready = (state_q == IDLE);
        SPI_SS    = !(state_q inside {SETUP, SHIFT, HOLD});
        SPI_SCK   = (state_q == SHIFT) && (cnt_q >= HALF);
        SPI_MOSI  = tx_q[31];
    end

    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
